// File: rtl/main_mem_pkg.sv
// Shared types and sizing helpers for the latency-configurable main-memory model.
package main_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Number of byte-offset address bits below the word index.
    function automatic int off_bits(input int data_w);
        return clog2(data_w / 8);
    endfunction

    // The latency counter holds LATENCY-1 and must never be zero bits wide.
    function automatic int cnt_bits(input int latency);
        return (clog2(latency) < 1) ? 1 : clog2(latency);
    endfunction

endpackage

// File: rtl/mem_array_be.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module mem_array_be #(
    parameter int DATA_W    = 32,
    parameter int ADDR_BITS = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_BITS;

    // One 8-bit-wide array per byte lane so each lane maps onto its own RAM write enable.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] mem_lane [0:DEPTH-1];
        logic [7:0] rd_lane_reg;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    if (be[gi]) begin
                        mem_lane[addr] <= wdata[gi*8 +: 8];
                    end
                end else begin
                    rd_lane_reg <= mem_lane[addr];
                end
            end
        end

        assign rdata[gi*8 +: 8] = rd_lane_reg;
    end

endmodule

// File: rtl/main_mem_lat.sv
// Main-memory model: one outstanding valid/ready transaction, fixed access latency,
// byte-enable writes and out-of-range error responses.
module main_mem_lat
    import main_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [DATA_W/8-1:0]  req_be,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err
);

    localparam int OFF    = off_bits(DATA_W);
    localparam int NB     = DATA_W / 8;
    localparam int CNT_W  = cnt_bits(LATENCY);
    localparam int IDX_HI = OFF + DEPTH_LOG2;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   we_reg;
    logic [DEPTH_LOG2-1:0]  idx_reg;
    logic                   oor_reg;
    logic [DATA_W-1:0]      wdata_reg;
    logic [NB-1:0]          be_reg;
    logic                   err_reg;
    logic                   rd_ok_reg;
    logic                   accept;
    logic                   commit;
    logic                   ram_en;
    logic [DATA_W-1:0]      ram_rdata;

    // Byte-offset bits never select anything.
    if (OFF > 0) begin : g_unused_off
        logic unused_off;
        assign unused_off = ^req_addr[OFF-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            idx_reg   <= '0;
            oor_reg   <= 1'b0;
            wdata_reg <= '0;
            be_reg    <= '0;
            err_reg   <= 1'b0;
            rd_ok_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= req_we;
                idx_reg   <= req_addr[IDX_HI-1:OFF];
                oor_reg   <= ((req_addr >> IDX_HI) != '0);
                wdata_reg <= req_wdata;
                be_reg    <= req_be;
            end
            // Response qualifiers are set at commit so they line up with the RAM read register.
            if (commit) begin
                err_reg   <= oor_reg;
                rd_ok_reg <= !we_reg && !oor_reg;
            end else if (state_reg == RESP && rsp_ready) begin
                err_reg   <= 1'b0;
                rd_ok_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_W'(LATENCY - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    commit     = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ram_en = commit && !oor_reg;

    mem_array_be #(
        .DATA_W    (DATA_W),
        .ADDR_BITS (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_reg),
        .be    (be_reg),
        .addr  (idx_reg),
        .wdata (wdata_reg),
        .rdata (ram_rdata)
    );

    assign rsp_rdata = rd_ok_reg ? ram_rdata : '0;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_main_mem_lat.sv
// Scoreboard bench: two memory instances (32-bit/latency 5 and 128-bit/latency 1).
module tb_main_mem_lat;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic          a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0]   a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]    a_req_be;
    logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0]   b_req_addr;
    logic [127:0]  b_req_wdata, b_rsp_rdata;
    logic [15:0]   b_req_be;

    main_mem_lat #(.ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(12), .LATENCY(5)) u_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    main_mem_lat #(.ADDR_W(32), .DATA_W(128), .DEPTH_LOG2(8), .LATENCY(1)) u_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    typedef struct {
        logic [127:0] rdata;
        logic         err;
        int           acc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t a_e, b_e;
    int   a_last_acc = 0, a_last_hs = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic a_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] erd, input logic eerr);
        exp_t e;
        int   n;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_be = be;
        n = 0;
        while (!a_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!a_req_ready) begin
            checks++; errors++;
            $display("FAIL a_accept_timeout actual=not_ready required=ready addr=%0h", addr);
            a_req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            a_req_valid = 1'b0;
            e.rdata = 128'(erd); e.err = eerr; e.acc = cyc;
            qa.push_back(e);
            a_last_acc = cyc;
        end
    endtask

    task automatic b_req(input logic we, input logic [31:0] addr, input logic [127:0] wd,
                         input logic [15:0] be, input logic [127:0] erd, input logic eerr);
        exp_t e;
        int   n;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd; b_req_be = be;
        n = 0;
        while (!b_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!b_req_ready) begin
            checks++; errors++;
            $display("FAIL b_accept_timeout actual=not_ready required=ready addr=%0h", addr);
            b_req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            b_req_valid = 1'b0;
            e.rdata = erd; e.err = eerr; e.acc = cyc;
            qb.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 128'(qa.size() + qb.size()), 0);
    endtask

    // Monitor A: latency, response contents, and stability under backpressure.
    logic        a_prev = 1'b0;
    int          a_first = 0, a_stall = 0;
    logic [31:0] a_hold_d;
    logic        a_hold_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            a_prev  = 1'b0;
            a_stall = 0;
        end else begin
            if (a_rsp_valid && !a_prev) a_first = cyc;
            if (a_rsp_valid && !a_rsp_ready) begin
                if (a_stall > 0) begin
                    chk("a_hold_rdata", 128'(a_rsp_rdata), 128'(a_hold_d));
                    chk("a_hold_err", 128'(a_rsp_err), 128'(a_hold_e));
                end
                chk("a_busy_req_ready", 128'(a_req_ready), 0);
                a_hold_d = a_rsp_rdata;
                a_hold_e = a_rsp_err;
                a_stall++;
            end else if (a_rsp_valid && a_rsp_ready) begin
                a_stall = 0;
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_rsp actual=rsp_valid required=no_rsp");
                end else begin
                    a_e = qa.pop_front();
                    $display("A rsp rdata=%08h err=%0d latency=%0d", a_rsp_rdata, a_rsp_err, a_first - a_e.acc);
                    chk("a_rdata", 128'(a_rsp_rdata), a_e.rdata);
                    chk("a_err", 128'(a_rsp_err), 128'(a_e.err));
                    chk("a_latency", 128'(a_first - a_e.acc), 5);
                end
                a_last_hs = cyc + 1;
            end
            a_prev = a_rsp_valid;
        end
    end

    logic b_prev = 1'b0;
    int   b_first = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            b_prev = 1'b0;
        end else begin
            if (b_rsp_valid && !b_prev) b_first = cyc;
            if (b_rsp_valid && b_rsp_ready) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_rsp actual=rsp_valid required=no_rsp");
                end else begin
                    b_e = qb.pop_front();
                    $display("B rsp rdata=%032h err=%0d latency=%0d", b_rsp_rdata, b_rsp_err, b_first - b_e.acc);
                    chk("b_rdata", b_rsp_rdata, b_e.rdata);
                    chk("b_err", 128'(b_rsp_err), 128'(b_e.err));
                    chk("b_latency", 128'(b_first - b_e.acc), 1);
                end
            end
            b_prev = b_rsp_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    localparam logic [127:0] LINE  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] LINE2 = 128'hFF23456789ABCDEF_FEDCBA98765432FF;

    initial begin
        int n;
        rst_n = 1'b0;
        a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0; a_rsp_ready = 1;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0; b_rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_req_ready", 128'(a_req_ready), 1);
        chk("rst_a_rsp_valid", 128'(a_rsp_valid), 0);
        chk("rst_a_rsp_rdata", 128'(a_rsp_rdata), 0);
        chk("rst_a_rsp_err", 128'(a_rsp_err), 0);
        chk("rst_b_req_ready", 128'(b_req_ready), 1);
        chk("rst_b_rsp_valid", 128'(b_rsp_valid), 0);
        chk("rst_b_rsp_rdata", b_rsp_rdata, 0);
        rst_n = 1'b1;

        // Basic write/read, byte enables, all-zero byte enables
        a_req(1, 32'h4, 32'h0000_0005, 4'hF, 0, 0);
        a_req(0, 32'h4, 0, 0, 32'h0000_0005, 0);
        a_req(1, 32'h8, 32'hAABB_CCDD, 4'hF, 0, 0);
        a_req(1, 32'h8, 32'h1122_3344, 4'b0101, 0, 0);
        a_req(0, 32'h8, 0, 0, 32'hAA22_CC44, 0);
        a_req(1, 32'h4, 32'hFFFF_FFFF, 4'h0, 0, 0);
        a_req(0, 32'h4, 0, 0, 32'h0000_0005, 0);

        // Range boundary and out-of-range accesses
        a_req(1, 32'h0, 32'hCAFE_F00D, 4'hF, 0, 0);
        a_req(1, 32'h3FFC, 32'h600D_D00D, 4'hF, 0, 0);
        a_req(1, 32'hFFFF_FFFC, 32'h0000_0076, 4'hF, 0, 1);
        a_req(0, 32'hFFFF_FFFC, 0, 0, 0, 1);
        a_req(0, 32'h0, 0, 0, 32'hCAFE_F00D, 0);
        a_req(0, 32'h3FFC, 0, 0, 32'h600D_D00D, 0);
        a_req(0, 32'h4000, 0, 0, 0, 1);

        // Backpressure with a request waiting behind the stalled response
        drain();
        @(posedge clk); #1 a_rsp_ready = 1'b0;
        a_req(0, 32'h8, 0, 0, 32'hAA22_CC44, 0);
        fork
            a_req(0, 32'h4, 0, 0, 32'h0000_0005, 0);
            begin
                n = 0;
                while (!a_rsp_valid && n < 100) begin
                    @(posedge clk);
                    n++;
                end
                repeat (10) @(posedge clk);
                #1 a_rsp_ready = 1'b1;
            end
        join
        chk("a_turnaround", 128'(a_last_acc - a_last_hs), 1);
        drain();

        // Reset during WAIT drops the in-flight write
        a_req(1, 32'h10, 32'h1234_5678, 4'hF, 0, 0);
        drain();
        a_req(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 128'(a_req_ready), 1);
        chk("midrst_rsp_valid", 128'(a_rsp_valid), 0);
        chk("midrst_rsp_rdata", 128'(a_rsp_rdata), 0);
        chk("midrst_rsp_err", 128'(a_rsp_err), 0);
        qa.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        a_req(0, 32'h10, 0, 0, 32'h1234_5678, 0);

        // 128-bit line, latency 1
        b_req(1, 32'h20, LINE, 16'hFFFF, 0, 0);
        b_req(0, 32'h20, 0, 0, LINE, 0);
        b_req(1, 32'h20, {128{1'b1}}, 16'h8001, 0, 0);
        b_req(0, 32'h20, 0, 0, LINE2, 0);
        b_req(0, 32'h1000, 0, 0, 0, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
